// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-path arbiter.
package axi_rd_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'd1;

  // arsize that covers the full data bus (log2 of bytes per beat)
  function automatic logic [SIZE_W-1:0] full_size(input int unsigned data_w);
    logic [SIZE_W-1:0] sz;
    sz = '0;
    for (int unsigned s = 0; s < 8; s++) begin
      if ((32'd8 << s) == data_w) sz = SIZE_W'(s);
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channels between the arbiter and the fabric.
interface axi_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational request picker: fixed priority from index 0, or round-robin from ptr.
module rr_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned IDX_W   = 1,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  // i-th candidate in search order, wrapping modulo N
  function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] p, input int unsigned i);
    int unsigned base;
    base = RR_MODE ? 32'(p) : 32'd0;
    return IDX_W'((base + i) % N);
  endfunction

  logic found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[slot(ptr, i)]) begin
        found                = 1'b1;
        gnt_oh[slot(ptr, i)] = 1'b1;
        gnt_idx              = slot(ptr, i);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master AXI4 read arbiter: one burst in flight, ARID carries the master index.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int unsigned N_MST     = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned RR_MODE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MST-1:0]         req_en,
  input  logic [N_MST*ADDR_W-1:0]  req_addr,
  input  logic [N_MST-1:0]         req_single,
  input  logic [N_MST*SIZE_W-1:0]  req_size,
  output logic [N_MST-1:0]         req_ok,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [N_MST-1:0]         rsp_valid,
  output logic [N_MST-1:0]         rsp_last,
  output logic [N_MST-1:0]         rsp_err,
  axi_rd_arbiter_if.master         axi
);

  localparam int unsigned IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [LEN_W-1:0]  BURST_ARLEN = LEN_W'(BURST_LEN - 1);
  localparam logic [SIZE_W-1:0] BURST_SIZE  = full_size(DATA_W);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, rr_ptr_q, arb_idx;
  logic [N_MST-1:0]    arb_oh;
  logic [ADDR_W-1:0]   sel_addr, araddr_q;
  logic                sel_single;
  logic [SIZE_W-1:0]   sel_size, arsize_q;
  logic [LEN_W-1:0]    arlen_q;
  logic [BURST_W-1:0]  arburst_q;
  logic                arvalid_q, rready_q;
  logic                rid_hit, beat_acc;
  logic [LEN_W:0]      beat_cnt_q;

  rr_arbiter #(
    .N       (N_MST),
    .IDX_W   (IDX_W),
    .RR_MODE (RR_MODE != 0)
  ) u_arb (
    .req     (req_en),
    .ptr     (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  // Select the winner's request fields
  always_comb begin
    sel_addr   = '0;
    sel_single = 1'b0;
    sel_size   = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_single = req_single[i];
        sel_size   = req_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  assign rid_hit = (axi.rid == ID_W'(grant_q));

  // Next state, AR acknowledge and R beat acceptance
  always_comb begin
    state_d  = state_q;
    req_ok   = '0;
    beat_acc = 1'b0;
    unique case (state_q)
      IDLE: if (|arb_oh) state_d = ADDR;
      ADDR: begin
        if (axi.arready) begin
          req_ok[grant_q] = 1'b1;
          state_d         = DATA;
        end
      end
      DATA: begin
        if (axi.rvalid && rid_hit) begin
          beat_acc = 1'b1;
          if (axi.rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latched AR request, handshake flags, response registers and RR pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= BURST_FIXED;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rsp_data   <= '0;
      rsp_valid  <= '0;
      rsp_last   <= '0;
      rsp_err    <= '0;
      beat_cnt_q <= '0;
    end else begin
      arvalid_q <= (state_d == ADDR);
      rready_q  <= (state_d == DATA);
      if (state_q == IDLE && |arb_oh) begin
        grant_q   <= arb_idx;
        araddr_q  <= sel_addr;
        arlen_q   <= sel_single ? '0 : BURST_ARLEN;
        arsize_q  <= sel_single ? sel_size : BURST_SIZE;
        arburst_q <= sel_single ? BURST_FIXED : BURST_INCR;
      end
      rsp_valid <= '0;
      rsp_last  <= '0;
      rsp_err   <= '0;
      if (beat_acc) begin
        rsp_valid[grant_q] <= 1'b1;
        rsp_last[grant_q]  <= axi.rlast;
        rsp_err[grant_q]   <= (axi.rresp != '0);
        rsp_data           <= axi.rdata;
        if (axi.rlast && RR_MODE != 0)
          rr_ptr_q <= IDX_W'((32'(grant_q) + 32'd1) % N_MST);
      end
      if (state_q != DATA) beat_cnt_q <= '0;
      else if (beat_acc)   beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arid    = ID_W'(grant_q);
  assign axi.arvalid = arvalid_q;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.rready  = rready_q;

  // rlast must coincide with beat arlen+1 of the granted burst
  rlast_on_final_beat: assert property (@(posedge clk) disable iff (!rst)
    beat_acc |-> (axi.rlast == (beat_cnt_q == {1'b0, arlen_q})));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed plus randomized bench for axi_rd_arbiter with a queue-free reference model.
module tb_axi_rd_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned BL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_en, req_single, req_ok, rsp_valid, rsp_last, rsp_err;
  logic [N*AW-1:0] req_addr;
  logic [N*3-1:0]  req_size;
  logic [DW-1:0]   rsp_data;

  logic [N-1:0]    req_en_f, req_ok_f, rsp_valid_f, rsp_last_f, rsp_err_f;
  logic [N*AW-1:0] req_addr_f;
  logic [N*3-1:0]  req_size_f;
  logic [N-1:0]    req_single_f;
  logic [DW-1:0]   rsp_data_f;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();
  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus_f ();

  axi_rd_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .BURST_LEN(BL), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr), .req_single(req_single),
    .req_size(req_size), .req_ok(req_ok), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .axi(bus)
  );

  axi_rd_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .BURST_LEN(BL), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .req_en(req_en_f), .req_addr(req_addr_f), .req_single(req_single_f),
    .req_size(req_size_f), .req_ok(req_ok_f), .rsp_data(rsp_data_f), .rsp_valid(rsp_valid_f),
    .rsp_last(rsp_last_f), .rsp_err(rsp_err_f), .axi(bus_f)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: RR pointer and per-master request fields
  int          ptr;
  logic [AW-1:0] m_addr   [N];
  logic          m_single [N];
  logic [2:0]    m_size   [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_req(input logic [N-1:0] en);
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = m_addr[i];
      req_single[i]        = m_single[i];
      req_size[i*3 +: 3]   = m_size[i];
    end
    req_en = en;
  endtask

  // One full transaction: arbitration, AR handshake, R beats; optional reset at rst_beat
  task automatic run_burst(input logic [N-1:0] reqs, input int ar_delay, input int err_beat,
                           input bit stray, input int rst_beat);
    int w, n;
    logic [DW-1:0] d;
    logic [1:0] rr;
    apply_req(reqs);
    w = pick(reqs, ptr);
    step();
    check("arvalid", bus.arvalid, 1);
    check("araddr", bus.araddr, m_addr[w]);
    check("arlen", bus.arlen, m_single[w] ? 0 : BL - 1);
    check("arburst", bus.arburst, m_single[w] ? 0 : 1);
    check("arsize", bus.arsize, m_single[w] ? m_size[w] : 3'd2);
    check("arid", bus.arid, w);
    for (int k = 0; k < ar_delay; k++) begin
      bus.arready = 1'b0;
      #1 check("req_ok_wait", req_ok, 0);
      step();
      check("araddr_hold", bus.araddr, m_addr[w]);
      check("arid_hold", bus.arid, w);
    end
    bus.arready = 1'b1;
    #1 check("req_ok", req_ok, 1 << w);
    step();
    bus.arready = 1'b0;
    req_en[w]   = 1'b0;
    check("arvalid_clr", bus.arvalid, 0);
    check("rready", bus.rready, 1);
    n = m_single[w] ? 1 : BL;
    for (int b = 0; b < n; b++) begin
      if (stray && b == 0) begin
        bus.rvalid = 1'b1; bus.rid = 4'd3; bus.rdata = $urandom; bus.rresp = 2'b00; bus.rlast = 1'b1;
        step();
        check("stray_drop", rsp_valid, 0);
      end
      if (err_beat < 0 && $urandom_range(0, 3) == 0) begin
        bus.rvalid = 1'b0;
        step();
        check("gap_no_rsp", rsp_valid, 0);
      end
      if (b == rst_beat) begin
        bus.rvalid = 1'b0; req_en = '0; bus.arready = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ok", req_ok, 0);
        step();
        step();
        rst = 1'b1;
        ptr = 0;
        return;
      end
      rr = (err_beat < 0) ? 2'($urandom_range(0, 3)) : ((b == err_beat) ? 2'b10 : 2'b00);
      d  = $urandom;
      bus.rvalid = 1'b1; bus.rid = IW'(w); bus.rdata = d; bus.rresp = rr; bus.rlast = (b == n - 1);
      step();
      check("rsp_valid", rsp_valid, 1 << w);
      check("rsp_data", rsp_data, d);
      check("rsp_last", rsp_last, (b == n - 1) ? (1 << w) : 0);
      check("rsp_err", rsp_err, (rr != 2'b00) ? (1 << w) : 0);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    check("idle_rready", bus.rready, 0);
    check("idle_arvalid", bus.arvalid, 0);
    ptr = (w + 1) % N;
  endtask

  initial begin
    rst = 1'b0;
    ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = $urandom; m_single[i] = 1'b0; m_size[i] = 3'd0;
    end
    req_en = '0; req_addr = '0; req_single = '0; req_size = '0;
    req_en_f = '0; req_addr_f = '0; req_single_f = '1; req_size_f = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
    bus_f.arready = 1'b0; bus_f.rvalid = 1'b0; bus_f.rid = '0; bus_f.rdata = '0; bus_f.rresp = '0; bus_f.rlast = 1'b0;
    step();
    check("reset_arvalid", bus.arvalid, 0);
    check("reset_rready", bus.rready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    step();
    rst = 1'b1;
    step();

    // Line burst from master 1
    m_addr[1] = 32'h1FC0_0000; m_single[1] = 1'b0;
    run_burst(2'b10, 0, 99, 1'b0, -1);

    // Uncached byte read from master 0
    m_addr[0] = 32'hBFAF_8004; m_single[0] = 1'b1; m_size[0] = 3'd0;
    run_burst(2'b01, 0, 99, 1'b0, -1);

    // Stalled arready plus a stray beat for another ID
    m_single[1] = 1'b1; m_size[1] = 3'd2;
    run_burst(2'b10, 5, 99, 1'b1, -1);

    // Both requesting continuously: grants alternate
    m_single[0] = 1'b1; m_single[1] = 1'b1;
    for (int k = 0; k < 4; k++) run_burst(2'b11, 0, 99, 1'b0, -1);

    // Error response on beat 4 of a line burst
    m_single[0] = 1'b0;
    run_burst(2'b01, 0, 3, 1'b0, -1);

    // Randomized traffic
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) begin
        m_addr[i]   = $urandom;
        m_single[i] = ($urandom_range(0, 1) == 1);
        m_size[i]   = 3'($urandom_range(0, 2));
      end
      run_burst(2'($urandom_range(1, 3)), $urandom_range(0, 3), -1, ($urandom_range(0, 3) == 0), -1);
    end

    // Reset mid-burst with pointer at 1, then pointer must restart at 0
    m_single[0] = 1'b1;
    run_burst(2'b01, 0, 99, 1'b0, -1);
    m_single[1] = 1'b0;
    run_burst(2'b10, 0, 99, 1'b0, 7);
    m_single[1] = 1'b1;
    run_burst(2'b11, 0, 99, 1'b0, -1);
    run_burst(2'b10, 0, 99, 1'b0, -1);

    // Fixed-priority instance: master 0 wins while it keeps requesting
    req_en_f = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fx_arid", bus_f.arid, 0);
      bus_f.arready = 1'b1;
      #1 check("fx_req_ok", req_ok_f, 2'b01);
      step();
      bus_f.arready = 1'b0;
      bus_f.rvalid = 1'b1; bus_f.rid = 4'd0; bus_f.rlast = 1'b1; bus_f.rdata = 32'(k); bus_f.rresp = 2'b00;
      step();
      check("fx_rsp_valid", rsp_valid_f, 2'b01);
      bus_f.rvalid = 1'b0; bus_f.rlast = 1'b0;
    end
    req_en_f = 2'b10;
    step();
    check("fx_arid_m1", bus_f.arid, 1);
    bus_f.arready = 1'b1;
    #1 check("fx_req_ok_m1", req_ok_f, 2'b10);
    step();
    bus_f.arready = 1'b0; req_en_f = '0;
    bus_f.rvalid = 1'b1; bus_f.rid = 4'd1; bus_f.rlast = 1'b1; bus_f.rdata = 32'h0000_00A5;
    step();
    check("fx_rsp_valid_m1", rsp_valid_f, 2'b10);
    check("fx_rsp_data_m1", rsp_data_f, 32'h0000_00A5);
    bus_f.rvalid = 1'b0; bus_f.rlast = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
N-master AXI4 read-address/read-data arbiter. It generalises the fixed inst/data read mux into a parametrised block with selectable fixed-priority or round-robin arbitration. It tags each burst with the master index on ARID and routes R beats back by RID. It sits between the per-channel cache/uncached controllers and the AXI master port. Write channels are out of scope.

Parameters:
N_MST, 2, number of requesting masters (2..8); index 0 is highest priority in fixed mode.
ADDR_W, 32, address width.
DATA_W, 32, data width.
ID_W, 4, ARID/RID width; must satisfy 2**ID_W >= N_MST.
BURST_LEN, 16, beats for a cached (line) read; 1..256.
RR_MODE, 1, 1 = round-robin, 0 = fixed priority.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
req_en  in  N_MST  per-master read request; held until req_ok.
req_addr  in  N_MST*ADDR_W  request address, master i at slice i.
req_single  in  N_MST  1 = single-beat uncached read; 0 = BURST_LEN incr burst.
req_size  in  N_MST*3  arsize for single reads; bursts always use log2(DATA_W/8).
req_ok  out  N_MST  one-cycle pulse when AR of master i accepted.
rsp_data  out  DATA_W  registered copy of rdata, shared by all masters.
rsp_valid  out  N_MST  beat valid for master i.
rsp_last  out  N_MST  final beat for master i.
rsp_err  out  N_MST  rresp != 0 on this beat.
araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_W/8/3/2/ID_W/1  AXI AR; arlock, arcache, arprot tied to 0.
arready  in  1  AXI AR ready.
rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  AXI R.
rready  out  1  AXI R ready.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant=0, arvalid=0, all req_ok/rsp_valid/rsp_last/rsp_err=0, rsp_data=0, rready=0.
- FSM IDLE -> ADDR -> DATA -> IDLE. One outstanding burst at a time.
- IDLE: rready=0. If any req_en, pick a winner. In fixed mode, the lowest index wins. In RR mode, the first set bit at or after rr_ptr wins, wrapping modulo N_MST. Register grant, address, len, size and burst. Go to ADDR. Requests that arrive during ADDR or DATA wait.
- ADDR: arvalid=1 with the latched fields.
  - arlen = single ? 0 : BURST_LEN-1.
  - arburst = single ? FIXED(0) : INCR(1).
  - arid = grant, zero-extended.
  - AR fields stay stable while arvalid && !arready.
  - On arready: pulse req_ok[grant] in the same cycle (combinational from arready) and go to DATA.
- DATA: rready=1.
  - A beat is accepted when rvalid && rid==grant. One cycle later: rsp_valid[grant]=1, rsp_data=rdata, rsp_last[grant]=rlast, rsp_err[grant]=(rresp!=0).
  - A beat with rid!=grant is consumed and dropped. No rsp_valid is produced for it.
  - On an accepted beat with rlast: go to IDLE. In RR mode, rr_ptr = (grant+1) mod N_MST.
- Latency: req_en sampled at cycle 0 in IDLE -> arvalid at cycle 1. First rsp_valid comes 1 cycle after the first accepted R beat. Back-to-back bursts: IDLE is entered for 1 cycle after the rlast response, so the minimum gap between AR issues is 2 cycles after the rlast beat.
- Simultaneous events:
  - req_en deasserted by the master during ADDR is ignored; the latched request completes.
  - rlast arriving in the same cycle as a new req_en: the new request is arbitrated on the IDLE cycle that follows.
- Beat counting: an internal beat counter flags a protocol error if rlast arrives on a beat other than beat arlen+1 (sim assertion only, no RTL action).
- rsp_err does not abort the burst. The burst completes normally.

Decomposition:
- Package axi_rd_pkg:
  - state enum {IDLE, ADDR, DATA};
  - AXI burst constants BURST_FIXED=2'd0, BURST_INCR=2'd1;
  - function clog2-based default size.
- Sub-module rr_arbiter (N-bit request, pointer in, one-hot + index grant out, RR_MODE param). It is purely combinational and is reused later by the write-path arbiter.

Test Plan:
- Single master (N_MST=2): req_en[1]=1, addr 0x1FC0_0000, single=0, arready=1 -> arlen=15, arburst=1, arid=1, req_ok[1] pulse. 16 R beats with rid=1 -> 16 rsp_valid[1], rsp_last[1] on the 16th beat.
- Contention, RR_MODE=1: req_en=2'b11 held -> grants in order 0,1,0,1. Contention, RR_MODE=0 -> master 0 always wins while it keeps requesting.
- Uncached read: single=1, req_size=3'b000, addr 0xBFAF_8004 -> arlen=0, arburst=0, arsize=0. One beat rdata=0x0000_00A5 -> rsp_data=0xA5, rsp_last=1.
- arready held low 5 cycles -> AR fields stable, req_ok stays 0 until the arready cycle. A stray beat rid=3 during DATA -> dropped, no rsp_valid.
- rresp=2'b10 on beat 4 of 16 -> rsp_err pulses on beat 4 only, and the burst still ends on beat 16.
- rst asserted low mid-DATA (beat 7) -> all outputs 0 immediately, rr_ptr=0. After release, a new req_en[1] is granted cleanly.
